// File: rtl/led_blink_rate_decoder.sv
// ============================================================================
// Module   : led_blink_rate_decoder
// Purpose  : Measures the half-period of a 50%-duty blink signal, classifies
//            it as 100/50/10/1 Hz and reports the enable/switch code that
//            produced it, or "disabled" when the signal holds steady.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module led_blink_rate_decoder #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int TOL_SHIFT  = 3,
  parameter int LOCK_COUNT = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_led_sense,
  output logic o_enable,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_valid,
  output logic o_error
);

  // Nominal half-periods in clocks for each blink rate
  localparam int HP_100  = CLK_HZ / 200;
  localparam int HP_50   = CLK_HZ / 100;
  localparam int HP_10   = CLK_HZ / 20;
  localparam int HP_1    = CLK_HZ / 2;
  // One clock beyond the widest legal 1 Hz interval
  localparam int TIMEOUT = HP_1 + (HP_1 >> TOL_SHIFT) + 1;
  localparam int CW      = $clog2(TIMEOUT + 1);
  localparam int MW      = $clog2(LOCK_COUNT + 1);

  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT - 1);
  localparam logic [MW-1:0] LOCK_C     = MW'(LOCK_COUNT);

  // Inclusive acceptance windows, HP +/- (HP >> TOL_SHIFT)
  localparam logic [CW-1:0] LO_100 = CW'(HP_100 - (HP_100 >> TOL_SHIFT));
  localparam logic [CW-1:0] HI_100 = CW'(HP_100 + (HP_100 >> TOL_SHIFT));
  localparam logic [CW-1:0] LO_50  = CW'(HP_50 - (HP_50 >> TOL_SHIFT));
  localparam logic [CW-1:0] HI_50  = CW'(HP_50 + (HP_50 >> TOL_SHIFT));
  localparam logic [CW-1:0] LO_10  = CW'(HP_10 - (HP_10 >> TOL_SHIFT));
  localparam logic [CW-1:0] HI_10  = CW'(HP_10 + (HP_10 >> TOL_SHIFT));
  localparam logic [CW-1:0] LO_1   = CW'(HP_1 - (HP_1 >> TOL_SHIFT));
  localparam logic [CW-1:0] HI_1   = CW'(HP_1 + (HP_1 >> TOL_SHIFT));

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  logic          sync1, sync2, prev;
  logic          sense_edge;
  logic [CW-1:0] count;
  logic          cls_none;
  logic [1:0]    cls_code;

  state_t        state, state_nx;
  logic [1:0]    cand, cand_nx;
  logic [MW-1:0] match_cnt, match_nx;
  logic [1:0]    sw, sw_nx;
  logic          enable_nx, valid_nx, error_nx;

  // Both polarities of a synchronised transition mark an edge
  assign sense_edge = sync2 ^ prev;
  assign o_switch_1 = sw[1];
  assign o_switch_2 = sw[0];

  // Two-flop synchroniser followed by the previous-value flop
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= i_led_sense;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Interval counter: restarts at 1 on an edge, saturates at TIMEOUT
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else if (sense_edge) begin
      count <= CW'(1);
    end else if (count != TIMEOUT_C) begin
      count <= count + 1'b1;
    end
  end

  // Classify the interval ending on this edge; a saturated count lands in NONE
  always_comb begin
    cls_none = 1'b0;
    cls_code = 2'b00;
    if (count >= LO_100 && count <= HI_100) begin
      cls_code = 2'b00;
    end else if (count >= LO_50 && count <= HI_50) begin
      cls_code = 2'b01;
    end else if (count >= LO_10 && count <= HI_10) begin
      cls_code = 2'b10;
    end else if (count >= LO_1 && count <= HI_1) begin
      cls_code = 2'b11;
    end else begin
      cls_none = 1'b1;
    end
  end

  // State, candidate, match counter and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      cand      <= 2'b00;
      match_cnt <= '0;
      sw        <= 2'b00;
      o_enable  <= 1'b0;
      o_valid   <= 1'b0;
      o_error   <= 1'b0;
    end else begin
      state     <= state_nx;
      cand      <= cand_nx;
      match_cnt <= match_nx;
      sw        <= sw_nx;
      o_enable  <= enable_nx;
      o_valid   <= valid_nx;
      o_error   <= error_nx;
    end
  end

  // Lock/unlock decisions; an edge takes priority over the timeout
  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    match_nx  = match_cnt;
    sw_nx     = sw;
    enable_nx = o_enable;
    valid_nx  = o_valid;
    error_nx  = 1'b0;
    if (sense_edge) begin
      case (state)
        S_IDLE: begin
          // Interval ending here has no trustworthy start; discard it
          state_nx = S_ACQUIRE;
          match_nx = '0;
        end
        S_ACQUIRE: begin
          if (cls_none) begin
            error_nx = 1'b1;
            match_nx = '0;
          end else begin
            if (cls_code == cand) begin
              match_nx = match_cnt + 1'b1;
            end else begin
              cand_nx  = cls_code;
              match_nx = MW'(1);
            end
            if (match_nx == LOCK_C) begin
              state_nx  = S_LOCKED;
              valid_nx  = 1'b1;
              enable_nx = 1'b1;
              sw_nx     = cand_nx;
            end
          end
        end
        S_LOCKED: begin
          if (cls_none || cls_code != cand) begin
            error_nx = 1'b1;
            valid_nx = 1'b0;
            state_nx = S_ACQUIRE;
            if (cls_none) begin
              match_nx = '0;
            end else begin
              cand_nx  = cls_code;
              match_nx = MW'(1);
            end
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end else if (count == TIMEOUT_M1) begin
      // Steady input: report a valid "disabled" code once, as the count saturates
      state_nx  = S_IDLE;
      match_nx  = '0;
      enable_nx = 1'b0;
      sw_nx     = 2'b00;
      valid_nx  = 1'b1;
    end
  end

endmodule

`default_nettype wire
